// File: rtl/ddr_rd_stream_if.sv
// DDR read channel between ddr_rd_stream (master) and the DDR read port (slave).
// The request side is valid/ready; the response side is valid-only and in request order.
interface ddr_rd_stream_if #(
  parameter int DDR_W  = 64,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8
);
  logic [ADDR_W-1:0] rd_req_addr;
  logic [LEN_W-1:0]  rd_req_len;
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [DDR_W-1:0]  rd_resp_data;
  logic              rd_resp_valid;

  modport master (
    output rd_req_addr,
    output rd_req_len,
    output rd_req_valid,
    input  rd_req_ready,
    input  rd_resp_data,
    input  rd_resp_valid
  );

  modport slave (
    input  rd_req_addr,
    input  rd_req_len,
    input  rd_req_valid,
    output rd_req_ready,
    output rd_resp_data,
    output rd_resp_valid
  );
endinterface

// File: rtl/ddr_rd_stream.sv
// Issues one DDR read burst per tile row under a credit limit and forwards response beats.
// Optional stall counter output enabled by defining DDR_RD_STREAM_PERF_EN.
module ddr_rd_stream #(
  parameter int DDR_W           = 64,
  parameter int ADDR_W          = 32,
  parameter int LEN_W           = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  output logic              o_done,
  input  logic [ADDR_W-1:0] i_conf_base_addr,
  input  logic [3:0]        i_conf_row_num,
  input  logic [LEN_W-1:0]  i_conf_row_len,
  input  logic [ADDR_W-1:0] i_conf_row_stride,
  ddr_rd_stream_if.master   bus,
  output logic [DDR_W-1:0]  o_ddr_data,
  output logic              o_ddr_valid
`ifdef DDR_RD_STREAM_PERF_EN
  ,
  output logic [31:0]       o_perf_stall_cnt
`endif
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_stride;
  logic [3:0]        r_row_num;
  logic [LEN_W-1:0]  r_row_len;
  logic [3:0]        r_req_cnt;
  logic [3:0]        r_rcv_cnt;
  logic [LEN_W-1:0]  r_beat_cnt;
  logic [OW-1:0]     r_outstanding;
  logic [DDR_W-1:0]  r_ddr_data;
  logic              r_ddr_valid;

  logic w_idle;
  logic w_start;
  logic w_req_valid;
  logic w_req_fire;
  logic w_last_req;
  logic w_beat;
  logic w_burst_done;
  logic w_op_done;

  assign w_idle       = (r_state == S_IDLE);
  assign w_start      = w_idle && i_start;
  assign w_req_valid  = (r_state == S_REQ) && (r_outstanding < MAX_OUT);
  assign w_req_fire   = w_req_valid && bus.rd_req_ready;
  assign w_last_req   = w_req_fire && (r_req_cnt == r_row_num);
  // Beats outside an operation are dropped and never touch the counters.
  assign w_beat       = !w_idle && bus.rd_resp_valid;
  assign w_burst_done = w_beat && (r_beat_cnt == r_row_len);
  assign w_op_done    = w_burst_done && (r_rcv_cnt == r_row_num);

  assign bus.rd_req_valid = w_req_valid;
  assign bus.rd_req_addr  = r_addr;
  assign bus.rd_req_len   = r_row_len;
  assign o_done           = w_idle;
  assign o_ddr_data       = r_ddr_data;
  assign o_ddr_valid      = r_ddr_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (i_start)    r_state <= S_REQ;
        S_REQ:   if (w_last_req) r_state <= S_DRAIN;
        S_DRAIN: if (w_op_done)  r_state <= S_IDLE;
        default:                 r_state <= S_IDLE;
      endcase
    end
  end

  // Configuration is captured once so the caller may change conf_* while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stride  <= '0;
      r_row_num <= '0;
      r_row_len <= '0;
    end else if (w_start) begin
      r_stride  <= i_conf_row_stride;
      r_row_num <= i_conf_row_num;
      r_row_len <= i_conf_row_len;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_req_cnt <= '0;
    end else if (w_start) begin
      r_addr    <= i_conf_base_addr;
      r_req_cnt <= '0;
    end else if (w_req_fire) begin
      r_addr    <= r_addr + r_stride;
      r_req_cnt <= r_req_cnt + 4'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_start) begin
      r_beat_cnt <= '0;
      r_rcv_cnt  <= '0;
    end else if (w_beat) begin
      if (w_burst_done) begin
        r_beat_cnt <= '0;
        r_rcv_cnt  <= r_rcv_cnt + 4'(1);
      end else begin
        r_beat_cnt <= r_beat_cnt + LEN_W'(1);
      end
    end
  end

  // Credits: a request consumes one, a completed burst returns one.
  always_ff @(posedge clk) begin
    if (rst || w_start) begin
      r_outstanding <= '0;
    end else begin
      case ({w_req_fire, w_burst_done})
        2'b10:   r_outstanding <= r_outstanding + OW'(1);
        2'b01:   r_outstanding <= r_outstanding - OW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ddr_valid <= 1'b0;
      r_ddr_data  <= '0;
    end else begin
      r_ddr_valid <= w_beat;
      if (w_beat) begin
        r_ddr_data <= bus.rd_resp_data;
      end
    end
  end

`ifdef DDR_RD_STREAM_PERF_EN
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (rst || w_start) begin
      r_perf_stall <= '0;
    end else if (w_req_valid && !bus.rd_req_ready && (r_perf_stall != 32'hFFFF_FFFF)) begin
      r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign o_perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_ddr_rd_stream.sv
// Self-checking bench for ddr_rd_stream: randomized DDR responder plus an arithmetic model
// of the expected request addresses and beat counts.
module tb_ddr_rd_stream;
  localparam int DDR_W  = 64;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        done;
  logic [31:0] confBase;
  logic [31:0] confStride;
  logic [3:0]  confRowNum;
  logic [7:0]  confRowLen;
  logic [63:0] ddrData;
  logic        ddrValid;
`ifdef DDR_RD_STREAM_PERF_EN
  logic [31:0] perfStall;
`endif

  always #5 clk = ~clk;

  ddr_rd_stream_if #(.DDR_W(DDR_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  ddr_rd_stream #(
    .DDR_W(DDR_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_start(start),
    .o_done(done),
    .i_conf_base_addr(confBase),
    .i_conf_row_num(confRowNum),
    .i_conf_row_len(confRowLen),
    .i_conf_row_stride(confStride),
    .bus(bus),
    .o_ddr_data(ddrData),
    .o_ddr_valid(ddrValid)
`ifdef DDR_RD_STREAM_PERF_EN
    ,
    .o_perf_stall_cnt(perfStall)
`endif
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [31:0] hsAddr[$];
  logic [7:0]  hsLen[$];
  logic [63:0] expQ[$];
  logic [63:0] gotQ[$];
  int gotCyc[$];
  int doneCyc = -1;
  int reqBeats[$];
  int reqReadyCyc[$];
  int curLeft = 0;
  int burstAllow = 1000000;
  bit strayEn = 1'b0;
  bit respFlush = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // DDR model: logs handshakes and forwarded beats, answers each burst 2 cycles later in order.
  initial begin
    bit prevDone;
    logic [63:0] d;
    prevDone = 1'b1;
    bus.rd_resp_valid = 1'b0;
    bus.rd_resp_data = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.rd_req_valid && bus.rd_req_ready) begin
        hsAddr.push_back(bus.rd_req_addr);
        hsLen.push_back(bus.rd_req_len);
        reqBeats.push_back(int'(bus.rd_req_len) + 1);
        reqReadyCyc.push_back(cyc + 2);
      end
      if (ddrValid) begin
        gotQ.push_back(ddrData);
        gotCyc.push_back(cyc);
      end
      if (done && !prevDone) doneCyc = cyc;
      prevDone = done;
      bus.rd_resp_valid = 1'b0;
      if (respFlush) begin
        reqBeats.delete();
        reqReadyCyc.delete();
        curLeft = 0;
        respFlush = 1'b0;
      end else if (strayEn) begin
        bus.rd_resp_valid = 1'b1;
        bus.rd_resp_data = {$urandom, $urandom};
      end else begin
        if (curLeft == 0 && burstAllow > 0 && reqBeats.size() > 0 && cyc >= reqReadyCyc[0]) begin
          curLeft = reqBeats.pop_front();
          void'(reqReadyCyc.pop_front());
          burstAllow--;
        end
        if (curLeft > 0 && $urandom_range(0, 3) != 0) begin
          d = {$urandom, $urandom};
          bus.rd_resp_valid = 1'b1;
          bus.rd_resp_data = d;
          expQ.push_back(d);
          curLeft--;
        end
      end
    end
  end

  // Expected request i is at base + i*stride modulo 2^32 with length rowLen.
  function automatic int addrBad(logic [31:0] base, logic [31:0] stride, logic [7:0] rl);
    logic [31:0] e;
    for (int i = 0; i < hsAddr.size(); i++) begin
      e = base + stride * 32'(i);
      if (hsAddr[i] !== e || hsLen[i] !== rl) return i;
    end
    return -1;
  endfunction

  function automatic int dataBad();
    for (int i = 0; i < gotQ.size() && i < expQ.size(); i++)
      if (gotQ[i] !== expQ[i]) return i;
    return -1;
  endfunction

  function automatic int lastBeatCyc();
    return (gotCyc.size() > 0) ? gotCyc[gotCyc.size()-1] : -1;
  endfunction

  task automatic launch(input logic [31:0] base, input logic [31:0] stride,
                        input logic [3:0] rn, input logic [7:0] rl, input bit now);
    if (!now) begin
      @(posedge clk);
      #1;
    end
    hsAddr.delete(); hsLen.delete(); expQ.delete(); gotQ.delete(); gotCyc.delete();
    doneCyc = -1;
    confBase = base; confStride = stride; confRowNum = rn; confRowLen = rl;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input int limit, output bit timedOut);
    timedOut = 1'b1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      #1;
      if (done) begin
        timedOut = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL reset_done: got %0b want 1", done); end
    checks++; if (bus.rd_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_valid: got %0b want 0", bus.rd_req_valid); end
    checks++; if (bus.rd_req_addr !== 32'h0 || bus.rd_req_len !== 8'h0) begin errors++; $display("[TB] FAIL reset_req_addr_len: got %h/%h want 0/0", bus.rd_req_addr, bus.rd_req_len); end
    checks++; if (ddrValid !== 1'b0 || ddrData !== 64'h0) begin errors++; $display("[TB] FAIL reset_ddr_out: got %0b/%h want 0/0", ddrValid, ddrData); end
`ifdef DDR_RD_STREAM_PERF_EN
    checks++; if (perfStall !== 32'h0) begin errors++; $display("[TB] FAIL reset_perf: got %0d want 0", perfStall); end
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bit to;
    launch(32'h1000, 32'h400, 4'd3, 8'd7, 1'b0);
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_low: got %0b want 0", done); end
    checks++; if (bus.rd_req_valid !== 1'b1 || bus.rd_req_addr !== 32'h1000) begin errors++; $display("[TB] FAIL basic_first_req: got %0b/%h want 1/00001000", bus.rd_req_valid, bus.rd_req_addr); end
    waitDone(300, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL basic_timeout: done=%0b want 1", done); end
    checks++; if (hsAddr.size() !== 4 || addrBad(32'h1000, 32'h400, 8'd7) !== -1) begin errors++; $display("[TB] FAIL basic_requests: got %0d reqs, bad idx %0d want 4, -1", hsAddr.size(), addrBad(32'h1000, 32'h400, 8'd7)); end
    checks++; if (gotQ.size() !== 32) begin errors++; $display("[TB] FAIL basic_beat_count: got %0d want 32", gotQ.size()); end
    checks++; if (dataBad() !== -1) begin errors++; $display("[TB] FAIL basic_data: bad idx %0d got %h want %h", dataBad(), gotQ[dataBad()], expQ[dataBad()]); end
    checks++; if (doneCyc !== lastBeatCyc()) begin errors++; $display("[TB] FAIL basic_done_timing: done cyc %0d want last beat cyc %0d", doneCyc, lastBeatCyc()); end
  endtask

  task automatic test_credit();
    bit to;
    burstAllow = 0;
    launch(32'h2000, 32'h100, 4'd9, 8'd3, 1'b0);
    repeat (12) @(negedge clk);
    #1;
    checks++; if (hsAddr.size() !== 4 || bus.rd_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL credit_limit: got %0d reqs valid=%0b want 4 reqs valid=0", hsAddr.size(), bus.rd_req_valid); end
    burstAllow = 1;
    repeat (20) @(negedge clk);
    #1;
    checks++; if (hsAddr.size() !== 5 || bus.rd_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL credit_release: got %0d reqs valid=%0b want 5 reqs valid=0", hsAddr.size(), bus.rd_req_valid); end
    burstAllow = 1000000;
    waitDone(400, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL credit_timeout: done=%0b want 1", done); end
    checks++; if (hsAddr.size() !== 10 || addrBad(32'h2000, 32'h100, 8'd3) !== -1) begin errors++; $display("[TB] FAIL credit_requests: got %0d reqs bad idx %0d want 10, -1", hsAddr.size(), addrBad(32'h2000, 32'h100, 8'd3)); end
    checks++; if (gotQ.size() !== 40 || dataBad() !== -1) begin errors++; $display("[TB] FAIL credit_beats: got %0d beats bad idx %0d want 40, -1", gotQ.size(), dataBad()); end
  endtask

  task automatic test_stall();
    bit to;
    launch(32'h1000, 32'h400, 4'd3, 8'd7, 1'b0);
    for (int i = 0; i < 10 && hsAddr.size() < 1; i++) begin
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    bus.rd_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checks++; if (bus.rd_req_valid !== 1'b1 || bus.rd_req_addr !== 32'h1400 || bus.rd_req_len !== 8'd7) begin errors++; $display("[TB] FAIL stall_hold_%0d: got %0b/%h/%0d want 1/00001400/7", i, bus.rd_req_valid, bus.rd_req_addr, bus.rd_req_len); end
      @(posedge clk);
      #1;
    end
    bus.rd_req_ready = 1'b1;
    waitDone(300, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL stall_timeout: done=%0b want 1", done); end
    checks++; if (hsAddr.size() !== 4 || addrBad(32'h1000, 32'h400, 8'd7) !== -1) begin errors++; $display("[TB] FAIL stall_requests: got %0d reqs bad idx %0d want 4, -1", hsAddr.size(), addrBad(32'h1000, 32'h400, 8'd7)); end
    checks++; if (gotQ.size() !== 32 || dataBad() !== -1) begin errors++; $display("[TB] FAIL stall_beats: got %0d beats bad idx %0d want 32, -1", gotQ.size(), dataBad()); end
`ifdef DDR_RD_STREAM_PERF_EN
    checks++; if (perfStall !== 32'd5) begin errors++; $display("[TB] FAIL stall_perf: got %0d want 5", perfStall); end
`endif
  endtask

  // Fixed corner configurations followed by random ones, all checked against the model.
  task automatic test_configs();
    logic [31:0] baseT[3] = '{32'h40, 32'h0, 32'hFFFF_FC00};
    logic [31:0] strideT[3] = '{32'h10, 32'h1000, 32'h400};
    logic [3:0] rnT[3] = '{4'd0, 4'd15, 4'd1};
    logic [7:0] rlT[3] = '{8'd0, 8'd255, 8'd2};
    logic [31:0] b, s;
    logic [3:0] rn;
    logic [7:0] rl;
    int total;
    bit to;
    for (int t = 0; t < 8; t++) begin
      if (t < 3) begin
        b = baseT[t]; s = strideT[t]; rn = rnT[t]; rl = rlT[t];
      end else begin
        b = $urandom; s = $urandom; rn = 4'($urandom_range(0, 7)); rl = 8'($urandom_range(0, 63));
      end
      total = (int'(rn) + 1) * (int'(rl) + 1);
      launch(b, s, rn, rl, 1'b0);
      waitDone(2 * total + 100, to);
      checks++; if (to) begin errors++; $display("[TB] FAIL cfg%0d_timeout: done=%0b want 1", t, done); end
      checks++; if (hsAddr.size() !== int'(rn) + 1 || addrBad(b, s, rl) !== -1) begin errors++; $display("[TB] FAIL cfg%0d_requests: got %0d reqs bad idx %0d want %0d, -1", t, hsAddr.size(), addrBad(b, s, rl), int'(rn) + 1); end
      checks++; if (gotQ.size() !== total || dataBad() !== -1) begin errors++; $display("[TB] FAIL cfg%0d_beats: got %0d beats bad idx %0d want %0d, -1", t, gotQ.size(), dataBad(), total); end
      checks++; if (doneCyc !== lastBeatCyc()) begin errors++; $display("[TB] FAIL cfg%0d_done_timing: done cyc %0d want %0d", t, doneCyc, lastBeatCyc()); end
    end
  endtask

  task automatic test_stray();
    bit to;
    gotQ.delete();
    @(posedge clk);
    #1;
    strayEn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    strayEn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (gotQ.size() !== 0 || done !== 1'b1) begin errors++; $display("[TB] FAIL stray_idle: got %0d beats done=%0b want 0 beats done=1", gotQ.size(), done); end
    launch(32'h3000, 32'h80, 4'd2, 8'd5, 1'b0);
    waitDone(200, to);
    checks++; if (to || hsAddr.size() !== 3 || addrBad(32'h3000, 32'h80, 8'd5) !== -1) begin errors++; $display("[TB] FAIL stray_next_reqs: timeout=%0b got %0d reqs want 3", to, hsAddr.size()); end
    checks++; if (gotQ.size() !== 18 || dataBad() !== -1) begin errors++; $display("[TB] FAIL stray_next_beats: got %0d beats bad idx %0d want 18, -1", gotQ.size(), dataBad()); end
  endtask

  task automatic test_start_mid();
    bit to;
    launch(32'h5000, 32'h200, 4'd5, 8'd3, 1'b0);
    for (int i = 0; i < 20 && hsAddr.size() < 2; i++) begin
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    confBase = 32'h9000; confStride = 32'h4; confRowNum = 4'd1; confRowLen = 8'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(300, to);
    checks++; if (to || hsAddr.size() !== 6 || addrBad(32'h5000, 32'h200, 8'd3) !== -1) begin errors++; $display("[TB] FAIL startmid_reqs: timeout=%0b got %0d reqs bad idx %0d want 6, -1", to, hsAddr.size(), addrBad(32'h5000, 32'h200, 8'd3)); end
    checks++; if (gotQ.size() !== 24 || dataBad() !== -1) begin errors++; $display("[TB] FAIL startmid_beats: got %0d beats bad idx %0d want 24, -1", gotQ.size(), dataBad()); end
  endtask

  task automatic test_rst_drain();
    bit to;
    launch(32'h6000, 32'h100, 4'd1, 8'd15, 1'b0);
    for (int i = 0; i < 20 && hsAddr.size() < 2; i++) begin
      @(negedge clk);
      #1;
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    respFlush = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (done !== 1'b1 || bus.rd_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_drain: got done=%0b valid=%0b want 1/0", done, bus.rd_req_valid); end
    rst = 1'b0;
    launch(32'h7000, 32'h40, 4'd2, 8'd4, 1'b0);
    waitDone(200, to);
    checks++; if (to || hsAddr.size() !== 3 || addrBad(32'h7000, 32'h40, 8'd4) !== -1) begin errors++; $display("[TB] FAIL rst_next_reqs: timeout=%0b got %0d reqs want 3", to, hsAddr.size()); end
    checks++; if (gotQ.size() !== 15 || dataBad() !== -1 || doneCyc !== lastBeatCyc()) begin errors++; $display("[TB] FAIL rst_next_beats: got %0d beats bad idx %0d want 15, -1", gotQ.size(), dataBad()); end
  endtask

  task automatic test_back_to_back();
    bit to;
    launch(32'h8000, 32'h20, 4'd1, 8'd1, 1'b0);
    waitDone(100, to);
    checks++; if (to || gotQ.size() !== 4 || dataBad() !== -1) begin errors++; $display("[TB] FAIL b2b_first: timeout=%0b got %0d beats want 4", to, gotQ.size()); end
    launch(32'hA000, 32'h60, 4'd2, 8'd2, 1'b1);
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_accept: got done=%0b want 0", done); end
    waitDone(200, to);
    checks++; if (to || hsAddr.size() !== 3 || addrBad(32'hA000, 32'h60, 8'd2) !== -1) begin errors++; $display("[TB] FAIL b2b_second_reqs: timeout=%0b got %0d reqs want 3", to, hsAddr.size()); end
    checks++; if (gotQ.size() !== 9 || dataBad() !== -1) begin errors++; $display("[TB] FAIL b2b_second_beats: got %0d beats bad idx %0d want 9, -1", gotQ.size(), dataBad()); end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    confBase = '0; confStride = '0; confRowNum = '0; confRowLen = '0;
    bus.rd_req_ready = 1'b1;
    test_reset();
    test_basic();
    test_credit();
    test_stall();
    test_configs();
    test_stray();
    test_start_mid();
    test_rst_drain();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running at cycle %0d, want finished", cyc);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/ddr_rd_stream.md
# ddr_rd_stream

Upstream feeder for the DDR-to-buffer writer. On `start` it issues one DDR read burst per tile row, tracks outstanding bursts under a credit limit and returns the response beats as the `ddr_data`/`ddr_valid` stream. That stream drives the buffer writer, which has no backpressure. `done` signals that every requested beat has been forwarded.

## Interface
- `DDR_W`, `GLOBAL_PARAM::DDR_W`, DDR data beat width.
- `ADDR_W`, 32, DDR byte-address width.
- `LEN_W`, 8, burst length field width (beats-1).
- `MAX_OUTSTANDING`, 4, maximum bursts in flight (1..15).

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: one-cycle launch pulse, accepted only when idle.
- `done` out 1: high when idle.
- `conf_base_addr` in ADDR_W: byte address of row 0.
- `conf_row_num` in 4: rows-1.
- `conf_row_len` in LEN_W: beats per row minus 1.
- `conf_row_stride` in ADDR_W: byte offset between consecutive row start addresses.
- `rd_req_addr` out ADDR_W: burst start address.
- `rd_req_len` out LEN_W: burst length-1, always equal to `conf_row_len`.
- `rd_req_valid` out 1: request valid.
- `rd_req_ready` in 1: request accepted when high together with valid.
- `rd_resp_data` in DDR_W: response beat.
- `rd_resp_valid` in 1: response beat valid. Beats arrive in request order and cannot be stalled.
- `ddr_data` out DDR_W: forwarded beat.
- `ddr_valid` out 1: forwarded beat valid.

## Operation
- **FSM states:** IDLE, REQ, DRAIN.
- **IDLE:** `done`=1.
  - On `start`, latch all `conf_*`.
  - Load `rd_req_addr`=`conf_base_addr`, clear the row, beat and outstanding counters, then go to REQ.
- **REQ:**
  - `rd_req_valid`=1 whenever outstanding < MAX_OUTSTANDING.
  - On handshake: `rd_req_addr` += latched stride (wraps modulo 2^ADDR_W) and issued-row counter +1.
  - After the handshake for row `conf_row_num`, go to DRAIN.
- **Request stability:** while valid and not ready, `rd_req_addr`/`rd_req_len` hold stable and valid does not drop.
- **Response beat counter:** 0..`conf_row_len`; it increments on each `rd_resp_valid` while busy. At `conf_row_len` it wraps to 0, completes one burst, and increments the received-row counter.
- **Outstanding counter:** +1 on request handshake, -1 on burst completion. Both in the same cycle leaves it unchanged. It can never exceed MAX_OUTSTANDING.
- **DRAIN:** `rd_req_valid`=0. On completion of burst `conf_row_num`, go to IDLE.
- **Total forwarded beats:** (`conf_row_num`+1)·(`conf_row_len`+1). Maximum 16·256.
- **Out-of-operation beats:** `rd_resp_valid` while IDLE is dropped: no `ddr_valid`, counters untouched.
- **`start` while busy:** ignored.
- **`rst` mid-operation:** returns to IDLE immediately and abandons in-flight bursts. The environment guarantees no stale beats arrive after reset.

## Timing
- **Reset values:** `done`=1, `rd_req_valid`=0, `rd_req_addr`=0, `rd_req_len`=0, `ddr_valid`=0, `ddr_data`=0.
- **`start` at cycle T:**
  - `done`=0 at T+1.
  - First `rd_req_valid` at T+1.
- **Forward path:** `ddr_data`/`ddr_valid` = `rd_resp_data`/`rd_resp_valid` registered, 1-cycle latency, no bubbles inserted.
- **Completion:**
  - Last beat at `rd_resp_valid` cycle N appears on `ddr_valid` at N+1.
  - FSM enters IDLE and `done`=1 at N+1.
- **Next launch:** `start` accepted on the same cycle `done` is first seen high.
- **Issue rate:** one request per cycle, subject to ready and the credit limit.

## Configuration
- **`DDR_RD_STREAM_PERF_EN` defined:**
  - Adds output `perf_stall_cnt` [31:0], counting cycles with `rd_req_valid`=1 and `rd_req_ready`=0.
  - Cleared on accepted `start` and on `rst`; saturates at 0xFFFFFFFF.
- **Undefined:** port and counter absent; function otherwise identical.

## Test plan
- **Basic stream:** base=0x1000, stride=0x400, row_num=3, row_len=7, ready=1, responses 2 cycles after request.
  - Requests at addresses 0x1000, 0x1400, 0x1800, 0x1C00, each len 7.
  - 32 `ddr_valid` beats, data matches, `done` high 1 cycle after the last beat.
- **Credit limit:** MAX_OUTSTANDING=4, row_num=9, responses withheld.
  - Exactly 4 handshakes, then `rd_req_valid`=0.
  - Completing one burst releases exactly one further request.
- **Ready stall:** `rd_req_ready` low for 5 cycles on the second request.
  - Address 0x1400 held stable throughout.
  - With `DDR_RD_STREAM_PERF_EN`, `perf_stall_cnt`=5.
- **Boundaries:**
  - row_num=0, row_len=0: 1 request, 1 beat, `done` after 1 beat.
  - row_num=15, row_len=255: 4096 beats.
  - Address wrap: base=0xFFFFFC00, stride=0x400 gives second request at 0x0.
- **Robustness:**
  - Stray `rd_resp_valid` in IDLE produces no `ddr_valid`.
  - `start` pulsed mid-REQ is ignored.
  - `rst` mid-DRAIN gives `done`=1 and `rd_req_valid`=0 the next cycle; a new `start` then runs cleanly.
